// File: rtl/dataio_port_arbiter_if.sv
// Request/response bundle for the data IO port arbiter:
// two requester channels plus the shared downstream bus.
interface dataio_port_arbiter_if;
  logic        iCH0_REQ;
  logic        oCH0_BUSY;
  logic [1:0]  iCH0_ORDER;
  logic [3:0]  iCH0_MASK;
  logic        iCH0_RW;
  logic [13:0] iCH0_TID;
  logic [1:0]  iCH0_MMUMOD;
  logic [31:0] iCH0_PDT;
  logic [31:0] iCH0_ADDR;
  logic [31:0] iCH0_DATA;
  logic        oCH0_VALID;
  logic [31:0] oCH0_DATA;

  logic        iCH1_REQ;
  logic        oCH1_BUSY;
  logic [1:0]  iCH1_ORDER;
  logic [3:0]  iCH1_MASK;
  logic        iCH1_RW;
  logic [13:0] iCH1_TID;
  logic [1:0]  iCH1_MMUMOD;
  logic [31:0] iCH1_PDT;
  logic [31:0] iCH1_ADDR;
  logic [31:0] iCH1_DATA;
  logic        oCH1_VALID;
  logic [31:0] oCH1_DATA;

  logic        oDATAIO_REQ;
  logic [1:0]  oDATAIO_ORDER;
  logic [3:0]  oDATAIO_MASK;
  logic        oDATAIO_RW;
  logic [13:0] oDATAIO_TID;
  logic [1:0]  oDATAIO_MMUMOD;
  logic [31:0] oDATAIO_PDT;
  logic [31:0] oDATAIO_ADDR;
  logic [31:0] oDATAIO_DATA;
  logic        iDATAIO_BUSY;
  logic        iDATAIO_REQ;
  logic [31:0] iDATAIO_DATA;
  logic        oERR_ORPHAN;

  modport slave (
    input  iCH0_REQ, iCH0_ORDER, iCH0_MASK, iCH0_RW,
    input  iCH0_TID, iCH0_MMUMOD, iCH0_PDT, iCH0_ADDR,
    input  iCH0_DATA,
    output oCH0_BUSY, oCH0_VALID, oCH0_DATA,
    input  iCH1_REQ, iCH1_ORDER, iCH1_MASK, iCH1_RW,
    input  iCH1_TID, iCH1_MMUMOD, iCH1_PDT, iCH1_ADDR,
    input  iCH1_DATA,
    output oCH1_BUSY, oCH1_VALID, oCH1_DATA,
    output oDATAIO_REQ, oDATAIO_ORDER, oDATAIO_MASK,
    output oDATAIO_RW, oDATAIO_TID, oDATAIO_MMUMOD,
    output oDATAIO_PDT, oDATAIO_ADDR, oDATAIO_DATA,
    input  iDATAIO_BUSY, iDATAIO_REQ, iDATAIO_DATA,
    output oERR_ORPHAN
  );

  modport master (
    output iCH0_REQ, iCH0_ORDER, iCH0_MASK, iCH0_RW,
    output iCH0_TID, iCH0_MMUMOD, iCH0_PDT, iCH0_ADDR,
    output iCH0_DATA,
    input  oCH0_BUSY, oCH0_VALID, oCH0_DATA,
    output iCH1_REQ, iCH1_ORDER, iCH1_MASK, iCH1_RW,
    output iCH1_TID, iCH1_MMUMOD, iCH1_PDT, iCH1_ADDR,
    output iCH1_DATA,
    input  oCH1_BUSY, oCH1_VALID, oCH1_DATA,
    input  oDATAIO_REQ, oDATAIO_ORDER, oDATAIO_MASK,
    input  oDATAIO_RW, oDATAIO_TID, oDATAIO_MMUMOD,
    input  oDATAIO_PDT, oDATAIO_ADDR, oDATAIO_DATA,
    output iDATAIO_BUSY, iDATAIO_REQ, iDATAIO_DATA,
    input  oERR_ORPHAN
  );
endinterface

// File: rtl/dataio_port_arbiter.sv
// Two-channel arbiter for the core data IO port with an
// in-order tag FIFO that steers responses to the issuer.
module dataio_port_arbiter #(
  parameter int P_DEPTH          = 4,
  parameter int P_DEPTH_N        = 2,
  parameter int P_FIXED_PRIORITY = 0
) (
  input  logic iCLOCK,
  input  logic iRESET_SYNC,
  dataio_port_arbiter_if.slave bus
);

  localparam logic [P_DEPTH_N:0] L_FULL =
    (P_DEPTH_N+1)'(P_DEPTH);

  logic [P_DEPTH_N:0]   b_count;
  logic [P_DEPTH_N-1:0] b_wr_ptr;
  logic [P_DEPTH_N-1:0] b_rd_ptr;
  logic [P_DEPTH-1:0]   b_tag;
  logic                 b_last_grant;
  logic                 b_err;

  logic full;
  logic empty;
  logic grant_any;
  logic grant;
  logic accept;
  logic pop;
  logic orphan;
  logic head;
  logic both;

  assign full      = (b_count == L_FULL);
  assign empty     = (b_count == '0);
  assign both      = bus.iCH0_REQ && bus.iCH1_REQ;
  assign grant_any = bus.iCH0_REQ || bus.iCH1_REQ;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      both:
        grant = (P_FIXED_PRIORITY != 0) ?
                1'b0 : ~b_last_grant;
      bus.iCH1_REQ && !bus.iCH0_REQ:
        grant = 1'b1;
      default:
        grant = 1'b0;
    endcase
  end

  assign bus.oDATAIO_REQ =
    grant_any && !full && !iRESET_SYNC;
  assign accept =
    bus.oDATAIO_REQ && !bus.iDATAIO_BUSY;

  // With no request grant stays 0, so CH0 fields show.
  assign bus.oDATAIO_ORDER  = grant ?
    bus.iCH1_ORDER  : bus.iCH0_ORDER;
  assign bus.oDATAIO_MASK   = grant ?
    bus.iCH1_MASK   : bus.iCH0_MASK;
  assign bus.oDATAIO_RW     = grant ?
    bus.iCH1_RW     : bus.iCH0_RW;
  assign bus.oDATAIO_TID    = grant ?
    bus.iCH1_TID    : bus.iCH0_TID;
  assign bus.oDATAIO_MMUMOD = grant ?
    bus.iCH1_MMUMOD : bus.iCH0_MMUMOD;
  assign bus.oDATAIO_PDT    = grant ?
    bus.iCH1_PDT    : bus.iCH0_PDT;
  assign bus.oDATAIO_ADDR   = grant ?
    bus.iCH1_ADDR   : bus.iCH0_ADDR;
  assign bus.oDATAIO_DATA   = grant ?
    bus.iCH1_DATA   : bus.iCH0_DATA;

  assign bus.oCH0_BUSY = iRESET_SYNC || full ||
    bus.iDATAIO_BUSY || (bus.iCH1_REQ && grant);
  assign bus.oCH1_BUSY = iRESET_SYNC || full ||
    bus.iDATAIO_BUSY || (bus.iCH0_REQ && !grant);

  assign head   = b_tag[b_rd_ptr];
  assign pop    =
    bus.iDATAIO_REQ && !empty && !iRESET_SYNC;
  assign orphan =
    bus.iDATAIO_REQ && empty && !iRESET_SYNC;

  assign bus.oCH0_VALID  = pop && !head;
  assign bus.oCH1_VALID  = pop && head;
  assign bus.oCH0_DATA   = bus.iDATAIO_DATA;
  assign bus.oCH1_DATA   = bus.iDATAIO_DATA;
  assign bus.oERR_ORPHAN = b_err;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      b_count      <= '0;
      b_wr_ptr     <= '0;
      b_rd_ptr     <= '0;
      b_tag        <= '0;
      b_last_grant <= 1'b1;
      b_err        <= 1'b0;
    end else begin
      if (accept) begin
        b_tag[b_wr_ptr] <= grant;
        b_wr_ptr        <= b_wr_ptr + 1'b1;
        b_last_grant    <= grant;
      end
      if (pop) begin
        b_rd_ptr <= b_rd_ptr + 1'b1;
      end
      if (orphan) begin
        b_err <= 1'b1;
      end
      unique case ({accept, pop})
        2'b10:   b_count <= b_count + 1'b1;
        2'b01:   b_count <= b_count - 1'b1;
        default: b_count <= b_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dataio_port_arbiter.sv
// Bench for dataio_port_arbiter: round-robin and fixed
// priority instances checked against a queue model.
module tb_dataio_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dataio_port_arbiter_if if_rr();
  dataio_port_arbiter_if if_fx();

  dataio_port_arbiter #(
    .P_DEPTH(4), .P_DEPTH_N(2), .P_FIXED_PRIORITY(0)
  ) dut_rr (
    .iCLOCK(clk), .iRESET_SYNC(rst), .bus(if_rr.slave)
  );

  dataio_port_arbiter #(
    .P_DEPTH(4), .P_DEPTH_N(2), .P_FIXED_PRIORITY(1)
  ) dut_fx (
    .iCLOCK(clk), .iRESET_SYNC(rst), .bus(if_fx.slave)
  );

  virtual dataio_port_arbiter_if vif [2];

  logic        r   [2];
  logic [1:0]  ord [2];
  logic [3:0]  msk [2];
  logic        rw  [2];
  logic [13:0] tid [2];
  logic [1:0]  mmu [2];
  logic [31:0] pdt [2];
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic        dbusy;
  logic        resp;
  logic [31:0] rdata;

  bit mq [2][$];
  bit mlast [2];
  bit merr  [2];
  bit macc  [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      vif[i].iCH0_REQ    = r[0];
      vif[i].iCH0_ORDER  = ord[0];
      vif[i].iCH0_MASK   = msk[0];
      vif[i].iCH0_RW     = rw[0];
      vif[i].iCH0_TID    = tid[0];
      vif[i].iCH0_MMUMOD = mmu[0];
      vif[i].iCH0_PDT    = pdt[0];
      vif[i].iCH0_ADDR   = adr[0];
      vif[i].iCH0_DATA   = dat[0];
      vif[i].iCH1_REQ    = r[1];
      vif[i].iCH1_ORDER  = ord[1];
      vif[i].iCH1_MASK   = msk[1];
      vif[i].iCH1_RW     = rw[1];
      vif[i].iCH1_TID    = tid[1];
      vif[i].iCH1_MMUMOD = mmu[1];
      vif[i].iCH1_PDT    = pdt[1];
      vif[i].iCH1_ADDR   = adr[1];
      vif[i].iCH1_DATA   = dat[1];
      vif[i].iDATAIO_BUSY = dbusy;
      vif[i].iDATAIO_REQ  = resp;
      vif[i].iDATAIO_DATA = rdata;
    end
  endtask

  // Expected outputs follow from the queue of issuers,
  // the last winner and the sticky orphan flag.
  task automatic model_cycle(input int i);
    bit    full, g, ereq, acc, pop, hd;
    string p;
    p    = (i == 0) ? "rr" : "fx";
    full = (mq[i].size() == 4);
    if (r[0] && r[1]) g = (i == 1) ? 1'b0 : !mlast[i];
    else              g = r[1];
    ereq = (r[0] || r[1]) && !full && !rst;
    acc  = ereq && !dbusy;
    pop  = resp && !rst && (mq[i].size() > 0);
    hd   = (mq[i].size() > 0) ? mq[i][0] : 1'b0;
    chk({p, "_req"},    vif[i].oDATAIO_REQ,    ereq);
    chk({p, "_order"},  vif[i].oDATAIO_ORDER,  ord[g]);
    chk({p, "_mask"},   vif[i].oDATAIO_MASK,   msk[g]);
    chk({p, "_rw"},     vif[i].oDATAIO_RW,     rw[g]);
    chk({p, "_tid"},    vif[i].oDATAIO_TID,    tid[g]);
    chk({p, "_mmumod"}, vif[i].oDATAIO_MMUMOD, mmu[g]);
    chk({p, "_pdt"},    vif[i].oDATAIO_PDT,    pdt[g]);
    chk({p, "_addr"},   vif[i].oDATAIO_ADDR,   adr[g]);
    chk({p, "_wdata"},  vif[i].oDATAIO_DATA,   dat[g]);
    chk({p, "_busy0"},  vif[i].oCH0_BUSY,
        rst || full || dbusy || (r[1] && g == 1'b1));
    chk({p, "_busy1"},  vif[i].oCH1_BUSY,
        rst || full || dbusy || (r[0] && g == 1'b0));
    chk({p, "_valid0"}, vif[i].oCH0_VALID, pop && !hd);
    chk({p, "_valid1"}, vif[i].oCH1_VALID, pop && hd);
    if (pop && !hd) chk({p, "_rdata0"}, vif[i].oCH0_DATA, rdata);
    if (pop && hd)  chk({p, "_rdata1"}, vif[i].oCH1_DATA, rdata);
    chk({p, "_orphan"}, vif[i].oERR_ORPHAN, merr[i]);
    if (rst) begin
      mq[i].delete();
      mlast[i] = 1'b1;
      merr[i]  = 1'b0;
      acc      = 1'b0;
    end else begin
      if (resp) begin
        if (mq[i].size() == 0) merr[i] = 1'b1;
        else void'(mq[i].pop_front());
      end
      if (acc) begin
        mq[i].push_back(g);
        mlast[i] = g;
      end
    end
    if (i == 0) begin
      macc[0] = acc && !g;
      macc[1] = acc && g;
    end
  endtask

  task automatic settle();
    apply();
    #2;
  endtask

  task automatic step();
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r[0] = 1'b0; r[1] = 1'b0;
    resp = 1'b0; dbusy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    settle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vif[0] = if_rr;
    vif[1] = if_fx;
    for (int c = 0; c < 2; c++) begin
      ord[c] = 2'd2; msk[c] = 4'hf; rw[c] = 1'b0;
      tid[c] = 14'(c + 1); mmu[c] = 2'd0;
      pdt[c] = 32'h0; adr[c] = 32'h0; dat[c] = 32'h0;
      mlast[c] = 1'b1; merr[c] = 1'b0; macc[c] = 1'b0;
    end
    rdata = 32'h0;
    idle();
    settle();
    @(posedge clk);
    #1;

    // reset cycle
    settle();
    chk("rst_busy0", if_rr.oCH0_BUSY, 1);
    chk("rst_busy1", if_rr.oCH1_BUSY, 1);
    chk("rst_req",   if_rr.oDATAIO_REQ, 0);
    step();
    rst = 1'b0;

    // single read on CH0
    r[0] = 1'b1; adr[0] = 32'h0000_1000;
    settle();
    chk("t1_req",   if_rr.oDATAIO_REQ, 1);
    chk("t1_addr",  if_rr.oDATAIO_ADDR, 32'h1000);
    chk("t1_busy0", if_rr.oCH0_BUSY, 0);
    step();
    chk("t1_count", mq[0].size(), 1);
    r[0] = 1'b0;
    settle(); step();
    settle(); step();
    resp = 1'b1; rdata = 32'hDEAD_BEEF;
    settle();
    chk("t1_valid0", if_rr.oCH0_VALID, 1);
    chk("t1_data0",  if_rr.oCH0_DATA, 32'hDEAD_BEEF);
    chk("t1_valid1", if_rr.oCH1_VALID, 0);
    step();
    chk("t1_count0", mq[0].size(), 0);
    resp = 1'b0;

    // both requesting, responses every cycle
    do_reset();
    adr[0] = 32'hA0; adr[1] = 32'hB0;
    r[0] = 1'b1; r[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin r[0] = 1'b0; r[1] = 1'b0; end
      resp = (k >= 1); rdata = 32'h100 + k;
      settle();
      if (k < 5) begin
        chk("t2_rr_grant", if_rr.oDATAIO_ADDR,
            (k % 2 == 0) ? 32'hA0 : 32'hB0);
        chk("t2_fx_grant", if_fx.oDATAIO_ADDR, 32'hA0);
        chk("t2_fx_busy1", if_fx.oCH1_BUSY, 1);
      end
      if (k >= 1) begin
        chk("t2_rr_v0", if_rr.oCH0_VALID, k % 2 == 1);
        chk("t2_rr_v1", if_rr.oCH1_VALID, k % 2 == 0);
        chk("t2_fx_v0", if_fx.oCH0_VALID, 1);
      end
      step();
    end
    idle();

    // downstream backpressure on CH1
    r[1] = 1'b1; adr[1] = 32'hC0;
    for (int k = 0; k < 6; k++) begin
      dbusy = (k < 5);
      settle();
      chk("t3_busy1", if_rr.oCH1_BUSY, k < 5);
      chk("t3_count", mq[0].size(), 0);
      step();
    end
    idle();
    chk("t3_count1", mq[0].size(), 1);
    resp = 1'b1;
    settle();
    chk("t3_valid1", if_rr.oCH1_VALID, 1);
    step();
    idle();

    // fill the tag FIFO with CH0 writes
    r[0] = 1'b1; rw[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      resp = (k == 5);
      settle();
      chk("t4_busy0", if_rr.oCH0_BUSY, k == 4 || k == 5);
      chk("t4_req", if_rr.oDATAIO_REQ, !(k == 4 || k == 5));
      if (k == 5) chk("t4_pop_v0", if_rr.oCH0_VALID, 1);
      step();
    end
    idle();
    rw[0] = 1'b0;
    chk("t4_count", mq[0].size(), 4);
    for (int k = 0; k < 4; k++) begin
      resp = 1'b1; rdata = 32'h400 + k;
      settle();
      chk("t4_drain_v0", if_rr.oCH0_VALID, 1);
      step();
    end
    idle();

    // push and pop in the same cycle
    r[1] = 1'b1; settle(); step();
    r[1] = 1'b0; r[0] = 1'b1; settle(); step();
    resp = 1'b1;
    settle();
    chk("t5_v1",    if_rr.oCH1_VALID, 1);
    chk("t5_busy0", if_rr.oCH0_BUSY, 0);
    step();
    chk("t5_count", mq[0].size(), 2);
    r[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t5_v0", if_rr.oCH0_VALID, 1);
      step();
    end
    idle();

    // reset with tags outstanding, then a late response
    r[0] = 1'b1; settle(); step();
    settle(); step();
    do_reset();
    chk("t6_count", mq[0].size(), 0);
    resp = 1'b1;
    settle();
    chk("t6_err0", if_rr.oERR_ORPHAN, 0);
    chk("t6_v0",   if_rr.oCH0_VALID, 0);
    chk("t6_v1",   if_rr.oCH1_VALID, 0);
    step();
    resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t6_err1", if_rr.oERR_ORPHAN, 1);
      step();
    end
    do_reset();
    settle();
    chk("t6_err_clr", if_rr.oERR_ORPHAN, 0);
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!r[c] || macc[c]) begin
          r[c]   = 1'($urandom_range(0, 1));
          ord[c] = 2'($urandom_range(0, 2));
          msk[c] = 4'($urandom);
          rw[c]  = 1'($urandom);
          tid[c] = 14'($urandom);
          mmu[c] = 2'($urandom);
          pdt[c] = $urandom;
          adr[c] = $urandom;
          dat[c] = $urandom;
        end
      end
      dbusy = ($urandom_range(0, 3) == 0);
      if (mq[0].size() > 0) resp = 1'($urandom_range(0, 1));
      else resp = ($urandom_range(0, 19) == 0);
      rdata = $urandom;
      rst   = ($urandom_range(0, 99) == 0);
      settle();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dataio_port_arbiter.md
Name: dataio_port_arbiter

Overview:
- Shares the single core data IO port between two requesters: CH0 is the execute load/store port and CH1 is a secondary requester such as a table walker or debug access.
- Arbitrates requests onto the downstream oDATAIO_* bus.
- Records the granting channel of each accepted request in an in-order tag FIFO.
- Routes each returned iDATAIO_REQ/iDATAIO_DATA response back to the channel that issued it.

Parameters:
- P_DEPTH, 4: max outstanding accepted-but-unanswered requests; must be a power of two.
- P_DEPTH_N, 2: log2(P_DEPTH).
- P_FIXED_PRIORITY, 0: 0 = round-robin; 1 = CH0 always wins.

Ports:
- iCLOCK  in  1  clock, rising edge.
- iRESET_SYNC  in  1  synchronous active-high reset; the only reset.
- iCHn_REQ  in  1  request strobe (n=0,1).
- oCHn_BUSY  out  1  request not accepted this cycle.
- iCHn_ORDER  in  2  00=byte, 01=2byte, 10=word.
- iCHn_MASK  in  4  byte mask.
- iCHn_RW  in  1  0=read, 1=write.
- iCHn_TID  in  14  task id.
- iCHn_MMUMOD  in  2  MMU mode.
- iCHn_PDT  in  32  page directory table base.
- iCHn_ADDR  in  32  address.
- iCHn_DATA  in  32  write data.
- oCHn_VALID  out  1  response pulse for channel n.
- oCHn_DATA  out  32  response data.
- oDATAIO_REQ, oDATAIO_ORDER[2], oDATAIO_MASK[4], oDATAIO_RW[1], oDATAIO_TID[14], oDATAIO_MMUMOD[2], oDATAIO_PDT[32], oDATAIO_ADDR[32], oDATAIO_DATA[32]  out  downstream request bus.
- iDATAIO_BUSY  in  1  downstream cannot accept.
- iDATAIO_REQ  in  1  downstream response pulse, one per accepted request (reads and writes), in order.
- iDATAIO_DATA  in  32  response data.
- oERR_ORPHAN  out  1  sticky: a response arrived with the FIFO empty.

Behaviour:
- Reset: all state clears on a rising iCLOCK edge with iRESET_SYNC=1.
  - FIFO count, read pointer and write pointer = 0.
  - b_last_grant = 1, so CH0 wins the first tie.
  - oERR_ORPHAN = 0.
  - During and after reset, all request outputs are combinational from the inputs and gated by the reset-cleared state. While iRESET_SYNC=1: oDATAIO_REQ=0, oCHn_VALID=0, oCHn_BUSY=1.
- Grant (combinational):
  - full = (count == P_DEPTH).
  - Only one channel requesting: grant that channel.
  - Both requesting, P_FIXED_PRIORITY=1: grant CH0.
  - Both requesting, P_FIXED_PRIORITY=0: grant the channel != b_last_grant.
- Downstream request, zero latency:
  - oDATAIO_REQ = grant_any && !full && !iRESET_SYNC.
  - All oDATAIO_* fields are muxed from the granted channel.
  - With no grant, the fields carry CH0 values with oDATAIO_REQ=0.
- Accept: accept = oDATAIO_REQ && !iDATAIO_BUSY.
- Channel busy:
  - oCHn_BUSY = iRESET_SYNC || full || iDATAIO_BUSY || (iCHm_REQ && grant != n), where m is the other channel.
  - A requester holds its request and fields stable until it sees a cycle with REQ=1 and BUSY=0.
- On accept:
  - Push the granted channel id into the FIFO at the write pointer; write pointer +1 mod P_DEPTH.
  - b_last_grant <= granted channel.
  - b_last_grant does not change without an accept.
- Response, iDATAIO_REQ=1:
  - If count != 0: pulse oCHk_VALID=1 for one cycle, where k = FIFO head; set oCHk_DATA = iDATAIO_DATA; pop, read pointer +1 mod P_DEPTH.
  - If count == 0: discard the response, set oERR_ORPHAN=1, leave pointers unchanged.
  - Response routing and its data are combinational, same cycle as iDATAIO_REQ.
  - The non-selected oCH_DATA is don't-care; drive iDATAIO_DATA to both.
- Count:
  - Accept and pop in the same cycle: count unchanged; the push goes to the write slot, the pop reads the head.
  - No same-cycle bypass: with count=0, a response in the accept cycle is an orphan.
  - Full is evaluated on the registered count. A pop in a full cycle does not lift BUSY that cycle; acceptance resumes next cycle.
- Pointers wrap modulo P_DEPTH. Count is P_DEPTH_N+1 bits, range 0..P_DEPTH.
- Reset mid-operation: outstanding tags are dropped. Late responses after reset are orphans and set oERR_ORPHAN. The pipeline is expected to hold downstream quiet across reset.
- Writes occupy a FIFO slot and receive oCHn_VALID like reads.

Test Plan:
1. Single read: CH0 REQ, ADDR=0x00001000, RW=0, BUSY=0.
   - Same cycle: oDATAIO_REQ=1, ADDR=0x1000, oCH0_BUSY=0; count becomes 1.
   - 3 cycles later iDATAIO_REQ=1, DATA=0xDEADBEEF -> oCH0_VALID=1, oCH0_DATA=0xDEADBEEF; oCH1_VALID=0; count returns to 0.
2. Round-robin: both channels request continuously, BUSY=0, responses returned every cycle.
   - Grants alternate CH0, CH1, CH0, CH1.
   - Responses route to CH0, CH1, CH0, CH1.
   - Repeat with P_FIXED_PRIORITY=1 -> CH0 granted every cycle; oCH1_BUSY=1 throughout.
3. Backpressure: CH1 requests with iDATAIO_BUSY=1 for 5 cycles.
   - oCH1_BUSY=1 and no FIFO push throughout.
   - b_last_grant unchanged; accepted on the 6th cycle.
4. Full: P_DEPTH=4, issue 4 CH0 writes with no responses.
   - 5th request sees oCH0_BUSY=1, oDATAIO_REQ=0.
   - A response with a pending request in the same cycle still gives BUSY=1; accepted next cycle.
   - Pointers wrap to 0 after 4 pushes.
5. Simultaneous push/pop: count=2 with heads CH1, CH0; a CH0 accept and a response arrive in the same cycle.
   - oCH1_VALID=1; count stays 2.
   - Next two responses route CH0, CH0.
6. Reset/orphan: 2 requests outstanding, pulse iRESET_SYNC 1 cycle.
   - count=0; oERR_ORPHAN=0 after reset.
   - Next iDATAIO_REQ -> no oCHn_VALID; oERR_ORPHAN=1 and sticky until the next reset.
